// File: rtl/pixel_unpacker.sv
`default_nettype none
// ============================================================================
// Module  : pixel_unpacker
// Brief   : Unpacks 3 x 32-bit stream words into 4 x 24-bit pixels with
//           frame/line position tracking and sticky framing error flags.
// Revision: 1.0
// ============================================================================
module pixel_unpacker #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic [9:0]  x_out,
  output logic [8:0]  y_out,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_valid,
  input  logic        pix_ready,
  input  logic        err_clr,
  output logic        sof_err,
  output logic        eol_err,
  output logic [15:0] frame_count
);

  localparam logic [9:0] c_X_LAST = 10'(X_SIZE - 1);
  localparam logic [9:0] c_X_PEN  = 10'(X_SIZE - 2);
  localparam logic [8:0] c_Y_LAST = 9'(Y_SIZE - 1);

  localparam logic [1:0] c_PH0 = 2'd0;
  localparam logic [1:0] c_PH1 = 2'd1;
  localparam logic [1:0] c_PH2 = 2'd2;
  localparam logic [1:0] c_PH3 = 2'd3;

  typedef enum logic [0:0] {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_phase;
  logic [1:0]  w_phase_nxt;
  logic [23:0] r_residue;
  logic [23:0] w_res_nxt;
  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic [23:0] r_pix;
  logic [9:0]  r_x_out;
  logic [8:0]  r_y_out;
  logic        r_sof;
  logic        r_eol;
  logic        r_pix_valid;
  logic        r_sof_err;
  logic        r_eol_err;
  logic [15:0] r_frame_count;

  logic        w_slot_free;
  logic        w_at_start;
  logic        w_tready;
  logic        w_load;
  logic        w_restart;
  logic        w_set_sof;
  logic        w_set_eol;
  logic        w_exp_last;
  logic [23:0] w_pix;
  logic [9:0]  w_cur_x;
  logic [8:0]  w_cur_y;
  logic [9:0]  w_nxt_x;
  logic [8:0]  w_nxt_y;
  logic        w_unused_tkeep;

  assign w_unused_tkeep = &in_stream_tkeep;
  assign w_slot_free    = !r_pix_valid || pix_ready;
  assign w_at_start     = (r_phase == c_PH0) && (r_x == 10'd0) && (r_y == 9'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_res_nxt   = r_residue;
    w_pix       = r_residue;
    w_load      = 1'b0;
    w_restart   = 1'b0;
    w_set_sof   = 1'b0;
    w_set_eol   = 1'b0;
    w_exp_last  = 1'b0;
    w_tready    = 1'b0;
    case (r_state)
      ST_SYNC: begin
        w_tready = 1'b1;
        if (in_stream_tvalid && in_stream_tuser) begin
          w_load      = 1'b1;
          w_restart   = 1'b1;
          w_pix       = in_stream_tdata[23:0];
          w_res_nxt   = {16'd0, in_stream_tdata[31:24]};
          w_phase_nxt = c_PH1;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_tready = (r_phase != c_PH3) && w_slot_free;
        if (in_stream_tvalid && w_tready) begin
          w_load     = 1'b1;
          // tuser anywhere but the expected frame start forces a fresh group at (0,0)
          w_restart  = in_stream_tuser && !w_at_start;
          w_set_sof  = w_restart;
          w_exp_last = !w_restart && (r_phase == c_PH2) && (r_x == c_X_PEN);
          w_set_eol  = (in_stream_tlast != w_exp_last);
          case (w_restart ? c_PH0 : r_phase)
            c_PH0: begin
              w_pix       = in_stream_tdata[23:0];
              w_res_nxt   = {16'd0, in_stream_tdata[31:24]};
              w_phase_nxt = c_PH1;
            end
            c_PH1: begin
              w_pix       = {in_stream_tdata[15:0], r_residue[7:0]};
              w_res_nxt   = {8'd0, in_stream_tdata[31:16]};
              w_phase_nxt = c_PH2;
            end
            default: begin
              w_pix       = {in_stream_tdata[7:0], r_residue[15:0]};
              w_res_nxt   = in_stream_tdata[31:8];
              w_phase_nxt = c_PH3;
            end
          endcase
        end else if ((r_phase == c_PH3) && w_slot_free) begin
          w_load      = 1'b1;
          w_phase_nxt = c_PH0;
        end
      end
    endcase
    if (reset) begin
      w_tready = 1'b0;
    end
  end

  always_comb begin
    w_cur_x = w_restart ? 10'd0 : r_x;
    w_cur_y = w_restart ? 9'd0  : r_y;
    w_nxt_x = w_cur_x + 10'd1;
    w_nxt_y = w_cur_y;
    if (w_cur_x == c_X_LAST) begin
      w_nxt_x = 10'd0;
      w_nxt_y = (w_cur_y == c_Y_LAST) ? 9'd0 : (w_cur_y + 9'd1);
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_SYNC;
      r_phase       <= c_PH0;
      r_residue     <= 24'd0;
      r_x           <= 10'd0;
      r_y           <= 9'd0;
      r_pix         <= 24'd0;
      r_x_out       <= 10'd0;
      r_y_out       <= 9'd0;
      r_sof         <= 1'b0;
      r_eol         <= 1'b0;
      r_pix_valid   <= 1'b0;
      r_sof_err     <= 1'b0;
      r_eol_err     <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_residue <= w_res_nxt;
      if (w_load) begin
        r_pix_valid <= 1'b1;
        r_pix       <= w_pix;
        r_x_out     <= w_cur_x;
        r_y_out     <= w_cur_y;
        r_sof       <= (w_cur_x == 10'd0) && (w_cur_y == 9'd0);
        r_eol       <= (w_cur_x == c_X_LAST);
        r_x         <= w_nxt_x;
        r_y         <= w_nxt_y;
      end else if (pix_ready) begin
        r_pix_valid <= 1'b0;
      end
      r_sof_err <= (r_sof_err && !err_clr) || w_set_sof;
      r_eol_err <= (r_eol_err && !err_clr) || w_set_eol;
      if (r_pix_valid && pix_ready && (r_x_out == c_X_LAST) && (r_y_out == c_Y_LAST)) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign in_stream_tready = w_tready;
  assign r           = r_pix[7:0];
  assign g           = r_pix[15:8];
  assign b           = r_pix[23:16];
  assign x_out       = r_x_out;
  assign y_out       = r_y_out;
  assign pix_sof     = r_sof;
  assign pix_eol     = r_eol;
  assign pix_valid   = r_pix_valid;
  assign sof_err     = r_sof_err;
  assign eol_err     = r_eol_err;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_pixel_unpacker.sv
`default_nettype none
// ============================================================================
// Module  : tb_pixel_unpacker
// Brief   : Directed self-checking bench for pixel_unpacker (8x3 frame).
// Revision: 1.0
// ============================================================================
module tb_pixel_unpacker;

  localparam int XS  = 8;
  localparam int YS  = 3;
  localparam int WPL = XS * 3 / 4;
  localparam int NW  = XS * YS * 3 / 4;
  localparam int NP  = XS * YS;

  logic        aclk = 1'b0;
  logic        reset;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tuser, tvalid, tready;
  logic [7:0]  r, g, b;
  logic [9:0]  x_out;
  logic [8:0]  y_out;
  logic        pix_sof, pix_eol, pix_valid, pix_ready;
  logic        err_clr, sof_err, eol_err;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [33:0] wq[$];
  logic [44:0] expq[$];
  logic [44:0] obs[$];

  always #5 aclk = ~aclk;

  pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
    .aclk(aclk), .reset(reset),
    .in_stream_tdata(tdata), .in_stream_tkeep(tkeep), .in_stream_tlast(tlast),
    .in_stream_tuser(tuser), .in_stream_tvalid(tvalid), .in_stream_tready(tready),
    .r(r), .g(g), .b(b), .x_out(x_out), .y_out(y_out),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .err_clr(err_clr), .sof_err(sof_err), .eol_err(eol_err), .frame_count(frame_count)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [44:0] cur_out();
    return {pix_sof, pix_eol, y_out, x_out, b, g, r};
  endfunction

  function automatic logic [23:0] pix_val(input int seed, input int i);
    return 24'(seed * 65793 + i * 197895 + 658188);
  endfunction

  // Packs a frame's pixels into words (inverse of the unpack mapping)
  task automatic build_frame(input int seed, input int keep_w, input int keep_p, input int bad_eol);
    logic [31:0] wa[NW];
    logic [23:0] p0, p1, p2, p3;
    for (int gi = 0; gi < NP / 4; gi++) begin
      p0 = pix_val(seed, 4 * gi);
      p1 = pix_val(seed, 4 * gi + 1);
      p2 = pix_val(seed, 4 * gi + 2);
      p3 = pix_val(seed, 4 * gi + 3);
      wa[3 * gi]     = {p1[7:0], p0};
      wa[3 * gi + 1] = {p2[15:0], p1[23:8]};
      wa[3 * gi + 2] = {p3, p2[23:16]};
    end
    for (int w = 0; w < keep_w; w++)
      wq.push_back({(w == 0), (((w % WPL) == WPL - 1) ^ (w == bad_eol)), wa[w]});
    for (int i = 0; i < keep_p; i++)
      expq.push_back({(i == 0), ((i % XS) == XS - 1), 9'(i / XS), 10'(i % XS), pix_val(seed, i)});
  endtask

  task automatic junk_words(input int n);
    for (int i = 0; i < n; i++) wq.push_back({1'b0, 1'b0, 32'($urandom)});
  endtask

  // mode 0: always ready, 1: toggling ready, 2: never ready
  task automatic run(input int mode, input int max_cycles);
    int cyc = 0;
    int drain = 0;
    bit stalled = 1'b0;
    logic [44:0] prev = '0;
    while (drain < 6 && cyc < max_cycles) begin
      tvalid = (wq.size() > 0);
      if (tvalid) {tuser, tlast, tdata} = wq[0];
      tkeep = 4'($urandom);
      pix_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'b0;
      #1;
      if (stalled) check("stall_hold", cur_out(), prev);
      if (pix_valid && !pix_ready) check("bp_tready", tready, 1'b0);
      if (tvalid && tready) void'(wq.pop_front());
      if (pix_valid && pix_ready) obs.push_back(cur_out());
      stalled = pix_valid && !pix_ready;
      prev = cur_out();
      if (wq.size() == 0) drain++;
      @(posedge aclk); #1;
      cyc++;
    end
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
    check("words_left", wq.size(), 0);
  endtask

  task automatic compare_pixels(input string tag);
    int n;
    check({tag, "_count"}, obs.size(), expq.size());
    n = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < n; i++) check(tag, obs[i], expq[i]);
    obs.delete();
    expq.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    reset = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge aclk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tdata = '0; tkeep = '0; tlast = 0; tuser = 0; tvalid = 0;
    pix_ready = 1'b0; err_clr = 1'b0;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    tvalid = 1'b1;
    #1;
    check("rst_tready", tready, 1'b0);
    check("rst_valid", pix_valid, 1'b0);
    check("rst_out", cur_out(), 45'd0);
    check("rst_errs", {sof_err, eol_err}, 2'b00);
    check("rst_fcnt", frame_count, 16'd0);
    tvalid = 1'b0;
    reset = 1'b0;
    @(posedge aclk); #1;

    // SYNC discards untagged words, then known unpack vector at (0,0)
    junk_words(10);
    run(0, 40);
    check("sync_nopix", obs.size(), 0);
    check("sync_valid", pix_valid, 1'b0);
    wq.push_back({1'b1, 1'b0, 32'h44332211});
    wq.push_back({1'b0, 1'b0, 32'h88776655});
    wq.push_back({1'b0, 1'b0, 32'hCCBBAA99});
    expq.push_back({1'b1, 1'b0, 9'd0, 10'd0, 24'h332211});
    expq.push_back({1'b0, 1'b0, 9'd0, 10'd1, 24'h665544});
    expq.push_back({1'b0, 1'b0, 9'd0, 10'd2, 24'h998877});
    expq.push_back({1'b0, 1'b0, 9'd0, 10'd3, 24'hCCBBAA});
    run(0, 40);
    if (obs.size() > 0) begin
      check("first_r", obs[0][7:0], 8'h11);
      check("first_b", obs[0][23:16], 8'h33);
    end
    compare_pixels("unpack");

    // Full frames: free-flowing then with toggled backpressure
    do_reset();
    build_frame(1, NW, NP, -1);
    run(0, 200);
    compare_pixels("frame");
    check("frame_fcnt", frame_count, 16'd1);
    check("frame_errs", {sof_err, eol_err}, 2'b00);
    build_frame(2, NW, NP, -1);
    run(1, 300);
    compare_pixels("bp_frame");
    check("bp_fcnt", frame_count, 16'd2);
    check("bp_errs", {sof_err, eol_err}, 2'b00);

    // Early tuser on line 1 restarts at (0,0)
    do_reset();
    build_frame(3, 10, 13, -1);
    build_frame(4, NW, NP, -1);
    if (expq.size() > 13) check("restart_pos", expq[13][44:24], {1'b1, 1'b0, 9'd0, 10'd0});
    run(0, 200);
    if (obs.size() > 13) check("restart_obs", obs[13][44:24], {1'b1, 1'b0, 9'd0, 10'd0});
    compare_pixels("sof_err_frame");
    check("sof_err_set", {sof_err, eol_err}, 2'b10);
    check("sof_err_fcnt", frame_count, 16'd1);
    pulse_clr();
    check("sof_err_clr", {sof_err, eol_err}, 2'b00);

    // tlast on a PH0 word: flag only, counters continue
    build_frame(5, NW, NP, 3);
    run(1, 300);
    compare_pixels("eol_err_frame");
    check("eol_err_set", {sof_err, eol_err}, 2'b01);
    check("eol_err_fcnt", frame_count, 16'd2);
    pulse_clr();
    check("eol_err_clr", {sof_err, eol_err}, 2'b00);

    // Asynchronous reset mid-line with a pending pixel
    do_reset();
    build_frame(6, 3, 4, -1);
    run(0, 40);
    compare_pixels("pre_rst");
    tvalid = 1'b1; tuser = 1'b0; tlast = 1'b0; tdata = 32'hDEADBEEF; pix_ready = 1'b0;
    @(posedge aclk); #1;
    tvalid = 1'b0;
    @(posedge aclk); #1;
    check("pre_rst_pend", {pix_valid, x_out}, {1'b1, 10'd4});
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", pix_valid, 1'b0);
    check("midrst_out", cur_out(), 45'd0);
    tvalid = 1'b1;
    @(posedge aclk); #1;
    check("midrst_tready", tready, 1'b0);
    tvalid = 1'b0;
    reset = 1'b0;
    @(posedge aclk); #1;
    junk_words(5);
    run(0, 40);
    check("post_rst_nopix", obs.size(), 0);
    build_frame(7, NW, NP, -1);
    run(0, 200);
    compare_pixels("post_rst_frame");
    check("post_rst_fcnt", frame_count, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_unpacker.md
PIXEL_UNPACKER -- requirements
Module: pixel_unpacker

Interface
REQ-001 SHALL have parameter X_SIZE, default 640, pixels per line; multiple of 4.
REQ-002 SHALL have parameter Y_SIZE, default 480, lines per frame.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port list:
aclk  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high
in_stream_tdata  in  32  packed pixel word
in_stream_tkeep  in  4  ignored
in_stream_tlast  in  1  last word of line
in_stream_tuser  in  1  first word of frame
in_stream_tvalid  in  1  word valid
in_stream_tready  out  1  word accepted when tvalid&tready
r, g, b  out  8 each  pixel colour
x_out  out  10  pixel column
y_out  out  9  pixel row
pix_sof  out  1  pixel is (0,0)
pix_eol  out  1  pixel is x=X_SIZE-1
pix_valid  out  1  pixel output valid
pix_ready  in  1  downstream accepts pixel
err_clr  in  1  clears sticky errors
sof_err  out  1  sticky: unexpected tuser
eol_err  out  1  sticky: tlast mismatch
frame_count  out  16  completed frames, wraps

Function
REQ-005 SHALL unpack 3 words into 4 pixels; 24-bit pixel P = {b,g,r}, r at P[7:0].
REQ-006 SHALL map per group, phase PH0..PH3: PH0 word w0 -> p0=w0[23:0], residue<=w0[31:24]; PH1 word w1 -> p1={w1[15:0],res[7:0]}, residue<=w1[31:16]; PH2 word w2 -> p2={w2[7:0],res[15:0]}, residue<=w2[31:8]; PH3 no word -> p3=res[23:0].
REQ-007 SHALL hold one registered pixel output slot; slot free = !pix_valid | pix_ready.
REQ-008 SHALL drive in_stream_tready = 1 in SYNC; in RUN = (phase!=PH3) & slot free.
REQ-009 SHALL load slot one cycle after word acceptance (latency 1); in PH3, load slot from residue on any cycle slot is free, no word consumed.
REQ-010 SHALL hold r,g,b,x_out,y_out,pix_sof,pix_eol stable while pix_valid & !pix_ready.
REQ-011 SHALL advance x on each slot load; at X_SIZE-1 wrap x to 0 and increment y; at (X_SIZE-1,Y_SIZE-1) wrap both to 0.
REQ-012 SHALL implement states SYNC and RUN; SYNC discards words until tuser=1; that word is w0 of pixel (0,0) and enters RUN.
REQ-013 SHALL, in RUN, on tuser=1 at any word other than expected frame start: set sof_err, restart at (0,0) PH0 treating word as w0; a pending slot pixel is still delivered.
REQ-014 SHALL, in RUN, expect tlast only on the PH2 word of the line's last group (pixel X_SIZE-2); any mismatch sets eol_err, no resync.
REQ-015 SHALL increment frame_count when pixel (X_SIZE-1,Y_SIZE-1) handshakes (pix_valid&pix_ready); wrap 16'hFFFF->0.
REQ-016 SHALL clear sof_err, eol_err on err_clr; simultaneous new error and err_clr leaves flag set.
REQ-017 SHALL ignore in_stream_tkeep.

Reset
REQ-018 SHALL, on reset assertion, immediately force state SYNC, phase PH0, x=y=0, residue 0, pix_valid 0, r=g=b=0, pix_sof=pix_eol=0, sof_err=eol_err=0, frame_count 0; in_stream_tready 0 while reset high.
REQ-019 SHALL discard any partial group or pending pixel on reset mid-frame; after release resync only on next tuser.

Verification
REQ-020 Frame: full 640x480 stream, tuser first word, tlast every 480th word, pix_ready=1 -> 307200 pixels, correct bytes, frame_count=1, no errors.
REQ-021 Unpack: words 0x44332211, 0x88776655, 0xCCBBAA99 at (0,0) -> pixels 0x332211, 0x665544, 0x998877, 0xCCBBAA; first r=0x11,b=0x33.
REQ-022 Backpressure: pix_ready toggled 1/0 -> tready low when slot full or PH3; no pixel lost or duplicated; outputs stable while stalled.
REQ-023 SYNC: 10 words with tuser=0 after reset then tuser word -> no pix_valid before tuser word; first pixel x=0,y=0,pix_sof=1.
REQ-024 Errors: tuser on word 5 of line 2 -> sof_err=1, next pixel (0,0); tlast on PH0 word -> eol_err=1, counters continue; err_clr -> both 0.
REQ-025 Reset mid-line at x=123 -> pix_valid 0 immediately, tready 0 during reset; after release no output until tuser.
